// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: request sizes, FSM states, lane widths.
package mem_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [WORD_W-1:0] rdata,
    input  logic [WORD_W-1:0] wdata,
    input  logic [1:0]        size,
    input  logic [1:0]        offset,
    input  logic              sign,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merged
);

    logic [BYTE_W-1:0] byte_lane;
    logic [HALF_W-1:0] half_lane;

    assign byte_lane = rdata[{offset, 3'b000} +: BYTE_W];
    assign half_lane = rdata[{offset[1], 4'b0000} +: HALF_W];

    always_comb begin
        load_data = rdata;
        merged    = wdata;
        if (size == SIZE_BYTE) begin
            load_data = sign ? {{(WORD_W-BYTE_W){byte_lane[BYTE_W-1]}}, byte_lane}
                             : {{(WORD_W-BYTE_W){1'b0}}, byte_lane};
            merged    = rdata;
            merged[{offset, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
        end else if (size == SIZE_HALF) begin
            load_data = sign ? {{(WORD_W-HALF_W){half_lane[HALF_W-1]}}, half_lane}
                             : {{(WORD_W-HALF_W){1'b0}}, half_lane};
            merged    = rdata;
            merged[{offset[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one request at a time against a word-wide memory,
// with read-modify-write for byte and half stores.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata
);

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

    state_e      state;
    logic        write_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        accept_c;
    logic        err_c;
    logic [31:0] load_c;
    logic [31:0] merged_c;

    assign accept_c = req_valid & req_ready;

    assign err_c = (req_size == SIZE_ILL)
                 | ((req_size == SIZE_HALF) & req_addr[0])
                 | ((req_size == SIZE_WORD) & (req_addr[1:0] != 2'b00))
                 | (req_addr >= ADDR_LIMIT);

    mem_lane_align u_lane_align (
        .rdata     (mem_readdata),
        .wdata     (wdata_q),
        .size      (size_q),
        .offset    (addr_q[1:0]),
        .sign      (signed_q),
        .load_data (load_c),
        .merged    (merged_c)
    );

    // Outputs are registered: each branch sets what the next state presents.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            write_q       <= 1'b0;
            signed_q      <= 1'b0;
            size_q        <= 2'b00;
            addr_q        <= '0;
            wdata_q       <= '0;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_err      <= 1'b0;
            resp_rdata    <= '0;
            MemRead       <= 1'b0;
            MemWrite      <= 1'b0;
            mem_addr      <= '0;
            mem_writedata <= '0;
        end else begin
            req_ready     <= 1'b0;
            resp_valid    <= 1'b0;
            resp_err      <= 1'b0;
            resp_rdata    <= '0;
            MemRead       <= 1'b0;
            MemWrite      <= 1'b0;
            mem_addr      <= '0;
            mem_writedata <= '0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept_c) begin
                        req_ready <= 1'b0;
                        write_q   <= req_write;
                        signed_q  <= req_signed;
                        size_q    <= req_size;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        if (err_c) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (!req_write || (req_size != SIZE_WORD)) begin
                            state    <= RD;
                            MemRead  <= 1'b1;
                            mem_addr <= {req_addr[31:2], 2'b00};
                        end else begin
                            state         <= WR;
                            MemWrite      <= 1'b1;
                            mem_addr      <= {req_addr[31:2], 2'b00};
                            mem_writedata <= req_wdata;
                        end
                    end
                end
                RD: begin
                    if (write_q) begin
                        state         <= WR;
                        MemWrite      <= 1'b1;
                        mem_addr      <= {addr_q[31:2], 2'b00};
                        mem_writedata <= merged_c;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_c;
                    end
                end
                WR: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: directed cases plus randomized loads/stores against a byte-lane reference model.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int unsigned MEM_WORDS = 32;
    localparam logic [31:0] LIMIT = 32'(MEM_WORDS * 4);

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_writedata, mem_readdata;
    logic        MemRead, MemWrite;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_addr      (mem_addr),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata)
    );

    always_comb begin
        mem_readdata = '0;
        if (MemRead && mem_addr < LIMIT) mem_readdata = mem[mem_addr[6:2]];
    end

    always @(posedge clk) begin
        if (MemWrite && mem_addr < LIMIT) mem[mem_addr[6:2]] <= mem_writedata;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Interface invariants that hold every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            check("strobe_excl", 64'(MemRead & MemWrite), 64'd0);
            if (!MemRead && !MemWrite) check("addr_idle", 64'(mem_addr), 64'd0);
            if (!resp_valid) check("resp_idle", {31'd0, resp_err, resp_rdata}, 64'd0);
        end
    end

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] got_rdata, output logic [31:0] got_wdata);
        logic        exp_err;
        logic [31:0] word, mask, loaded, merged, exp_rdata;
        int          shift, exp_lat, exp_rd, exp_wr;
        int          got_lat, n_rd, n_wr, first_rd, wr_k, t;

        got_rdata = '0;
        got_wdata = '0;
        got_lat = 0; n_rd = 0; n_wr = 0; first_rd = 0; wr_k = 0; t = 0;
        while (!req_ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("ready_before", 64'(req_ready), 64'd1);

        exp_err = (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
                  (sz == 2'b10 && a[1:0] != 2'b00) || (a >= LIMIT);
        word  = (a < LIMIT) ? ref_mem[a[6:2]] : 32'd0;
        shift = 8 * int'(a % 4);
        mask  = (sz == 2'b00) ? 32'h0000_00FF : (sz == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        loaded = (word >> shift) & mask;
        if (sg && sz != 2'b10 && (loaded & ~(mask >> 1)) != 0) loaded = loaded | ~mask;
        merged = (word & ~(mask << shift)) | ((wd & mask) << shift);
        exp_rdata = (exp_err || w) ? 32'd0 : loaded;
        exp_lat = exp_err ? 1 : (!w || sz == 2'b10) ? 2 : 3;
        exp_rd  = (exp_err || (w && sz == 2'b10)) ? 0 : 1;
        exp_wr  = (!exp_err && w) ? 1 : 0;

        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;

        for (int k = 1; k <= 6 && got_lat == 0; k++) begin
            @(negedge clk);
            if (MemRead) begin
                n_rd++;
                if (first_rd == 0) first_rd = k;
                check("rd_addr", 64'(mem_addr), 64'({a[31:2], 2'b00}));
            end
            if (MemWrite) begin
                n_wr++;
                wr_k = k;
                got_wdata = mem_writedata;
                check("wr_addr", 64'(mem_addr), 64'({a[31:2], 2'b00}));
                check("wr_data", 64'(mem_writedata), 64'(merged));
            end
            if (resp_valid) begin
                got_lat = k;
                got_rdata = resp_rdata;
                check("rdata", 64'(resp_rdata), 64'(exp_rdata));
                check("err", 64'(resp_err), 64'(exp_err));
                check("ready_in_resp", 64'(req_ready), 64'd0);
            end
        end
        check("latency", 64'(got_lat), 64'(exp_lat));
        check("reads", 64'(n_rd), 64'(exp_rd));
        check("writes", 64'(n_wr), 64'(exp_wr));
        if (exp_rd != 0) check("rd_cycle", 64'(first_rd), 64'd1);
        if (exp_wr != 0) check("wr_cycle", 64'(wr_k), 64'(exp_lat - 1));
        if (exp_wr != 0) ref_mem[a[6:2]] = merged;
        @(negedge clk);
        check("ready_after", 64'(req_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd, wdat, a, wd;
        logic [1:0]  sz;
        logic        w, sg;
        int          sel;

        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            mem[i]     = 32'(i);
            ref_mem[i] = 32'(i);
        end
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;

        repeat (3) @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_resp", {30'd0, resp_valid, resp_err, resp_rdata}, 64'd0);
        check("rst_strobes", 64'({MemRead, MemWrite}), 64'd0);
        check("rst_memaddr", 64'(mem_addr), 64'd0);
        check("rst_wdata", 64'(mem_writedata), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd, wdat);
        check("word_load_14", 64'(rd), 64'h0000_0005);

        do_req(1'b1, 2'b00, 1'b0, 32'h09, 32'h80, rd, wdat);
        check("byte_store_wdata", 64'(wdat), 64'h0000_8002);
        do_req(1'b0, 2'b00, 1'b1, 32'h09, 32'h0, rd, wdat);
        check("byte_load_signed", 64'(rd), 64'hFFFF_FF80);
        do_req(1'b0, 2'b00, 1'b0, 32'h09, 32'h0, rd, wdat);
        check("byte_load_unsigned", 64'(rd), 64'h0000_0080);

        do_req(1'b0, 2'b01, 1'b0, 32'h03, 32'h0, rd, wdat);
        do_req(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, rd, wdat);
        do_req(1'b1, 2'b11, 1'b0, 32'h04, 32'h1234, rd, wdat);

        do_req(1'b1, 2'b01, 1'b0, 32'h0E, 32'hBEEF, rd, wdat);
        check("half_store_wdata", 64'(wdat), 64'hBEEF_0003);
        do_req(1'b0, 2'b01, 1'b1, 32'h0E, 32'h0, rd, wdat);
        check("half_load_signed", 64'(rd), 64'hFFFF_BEEF);

        // Reset in the read half of a byte store must suppress the write.
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h08; req_wdata = 32'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_in_rd", 64'(MemRead), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_wr_in_rst", 64'(MemWrite), 64'd0);
        rst = 1'b0;
        check("abort_ready", 64'(req_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort_no_write", 64'(MemWrite), 64'd0);
            check("abort_no_resp", 64'(resp_valid), 64'd0);
        end
        check("abort_word2", 64'(mem[2]), 64'(ref_mem[2]));

        for (int n = 0; n < 200; n++) begin
            sel = int'($urandom_range(0, 9));
            sz  = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            w   = 1'($urandom_range(0, 1));
            sg  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            if ($urandom_range(0, 7) == 0) a = LIMIT + 32'($urandom_range(0, 64));
            else a = 32'($urandom_range(0, MEM_WORDS * 4 - 1));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            do_req(w, sz, sg, a, wd, rd, wdat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int i = 0; i < int'(MEM_WORDS); i++) check("final_mem", 64'(mem[i]), 64'(ref_mem[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 32, giving the number of 32-bit words in the attached data memory.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit: request present.
REQ-005 The block SHALL have port req_ready, output, 1 bit: unit can accept a request.
REQ-006 The block SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port req_size, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-008 The block SHALL have port req_signed, input, 1 bit: sign-extend a sub-word load.
REQ-009 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 The block SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port resp_rdata, output, 32 bits: load result.
REQ-013 The block SHALL have port resp_err, output, 1 bit: request rejected.
REQ-014 The block SHALL have port mem_addr, output, 32 bits: word-aligned byte address to memory.
REQ-015 The block SHALL have ports MemRead and MemWrite, outputs, 1 bit each: memory read and write strobes.
REQ-016 The block SHALL have port mem_writedata, output, 32 bits: full word to write.
REQ-017 The block SHALL have port mem_readdata, input, 32 bits: memory read data, combinationally valid in the same cycle MemRead is high.

Function
REQ-018 The FSM SHALL have states IDLE, RD, WR and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid & req_ready, and all request fields SHALL be registered at acceptance.
REQ-020 Error condition: size 11; half with addr[0]=1; word with addr[1:0]!=0; or addr >= MEM_WORDS*4.
REQ-021 An accepted request with an error SHALL go IDLE->RESP with resp_err=1 and SHALL NOT assert MemRead or MemWrite.
REQ-022 A load SHALL go IDLE->RD->RESP, asserting MemRead for exactly the RD cycle and capturing mem_readdata at the end of it; resp_valid is at acceptance+2.
REQ-023 A word store SHALL go IDLE->WR->RESP, asserting MemWrite for one cycle with mem_writedata=req_wdata; resp_valid is at acceptance+2.
REQ-024 A byte or half store SHALL perform read-modify-write, IDLE->RD->WR->RESP: read the word, replace only the addressed lane, write the merged word; resp_valid is at acceptance+3.
REQ-025 Byte lanes SHALL be little-endian: byte lane = bits [8*addr[1:0]+7 : 8*addr[1:0]]; half lane = bits [16*addr[1]+15 : 16*addr[1]].
REQ-026 A sub-word load result SHALL be zero-extended when req_signed=0 and sign-extended when req_signed=1; req_signed SHALL be ignored for word loads.
REQ-027 mem_addr SHALL equal {addr[31:2],2'b00} whenever MemRead or MemWrite is high, and 0 otherwise.
REQ-028 MemRead and MemWrite SHALL never be high in the same cycle.
REQ-029 In RESP, resp_valid SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE.
REQ-030 resp_rdata SHALL be 0 for stores and for errors; resp_err SHALL be 0 for successful requests.
REQ-031 resp_rdata and resp_err SHALL be valid only while resp_valid=1 and SHALL be 0 otherwise.
REQ-032 A new request SHALL NOT be accepted in the RESP cycle.

Reset
REQ-033 When rst=1 at a clock edge, the FSM SHALL go to IDLE and all captured fields SHALL clear.
REQ-034 During and after reset, outputs SHALL be: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, MemRead=0, MemWrite=0, mem_addr=0, mem_writedata=0.
REQ-035 Reset in any state SHALL abort the operation with no response and SHALL prevent any MemWrite in the following cycle.

Structure
REQ-036 Package mem_pkg SHALL hold the req_size encodings, the FSM state enum and the byte/half/word width constants.
REQ-037 Lane extract, extend and merge logic SHALL be a combinational sub-module mem_lane_align, instantiated once.

Verification
Memory is preloaded with word[i]=i. T is the acceptance cycle.
REQ-038 Word load addr 0x14: MemRead at T+1, resp_valid=1 with resp_rdata=0x00000005 at T+2.
REQ-039 Byte store 0x80 to addr 0x09: RD at T+1; MemWrite at T+2 with mem_addr=0x08, mem_writedata=0x00008002; resp at T+3. A following signed byte load from 0x09 SHALL return 0xFFFFFF80, and an unsigned one 0x00000080.
REQ-040 Half load addr 0x03 and word load addr 0x80 (MEM_WORDS=32): resp_err=1 at T+1, with no MemRead or MemWrite.
REQ-041 Half store 0xBEEF to addr 0x0E: mem_writedata=0xBEEF0003 at T+2.
REQ-042 rst asserted in the RD cycle of a byte store: no MemWrite is ever issued, no resp_valid, req_ready=1 the cycle after reset, and memory word 2 is unchanged.
